// File: rtl/gp_timer_scheduler.sv
// Round-robin scheduler sharing one COUNT8/COUNT14-style down-counter among NUM_REQ requesters.
// Define GP_TIMER_SCHED_PRIO_EN to give requester 0 absolute priority at arbitration.
module gp_timer_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 14,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic                     HOLD,
  input  logic [NUM_REQ*WIDTH-1:0] TIMEOUT,
  output logic [NUM_REQ-1:0]       GNT,
  output logic [IDX_W-1:0]         GNT_ID,
  output logic [NUM_REQ-1:0]       DONE,
  output logic                     ABORT,
  output logic                     BUSY,
  output logic [WIDTH-1:0]         COUNT,
  output logic                     EXPIRE,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COUNT = 2'd1, S_GAP = 2'd2} state_t;

  localparam logic [NUM_REQ-1:0] GNT_LSB = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST_ID = IDX_W'(NUM_REQ - 1);

  state_t               state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IDX_W-1:0]     gnt_id_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 abort_q;
  logic [WIDTH-1:0]     count_q;

  logic                 sel_valid_d;
  logic [IDX_W-1:0]     sel_idx_d;
  logic [WIDTH-1:0]     sel_tmo_d;
  logic [IDX_W-1:0]     ptr_d;

  // Walk offsets from highest to lowest so the nearest set bit at or after ptr wins.
  always_comb begin
    sel_valid_d = 1'b0;
    sel_idx_d   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (REQ[j]) begin
        sel_valid_d = 1'b1;
        sel_idx_d   = IDX_W'(j);
      end
    end
`ifdef GP_TIMER_SCHED_PRIO_EN
    if (REQ[0]) begin
      sel_valid_d = 1'b1;
      sel_idx_d   = '0;
    end
`endif
  end

  assign sel_tmo_d = TIMEOUT[sel_idx_d*WIDTH +: WIDTH];
  assign ptr_d     = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IDX_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      done_q   <= '0;
      abort_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      done_q  <= '0;
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sel_valid_d) begin
            gnt_q    <= GNT_LSB << sel_idx_d;
            gnt_id_q <= sel_idx_d;
            count_q  <= sel_tmo_d;
            state_q  <= S_COUNT;
          end
        end
        S_COUNT: begin
          // A dropped request beats expiry; the counter keeps its value on abort.
          if (!REQ[gnt_id_q]) begin
            gnt_q   <= '0;
            abort_q <= 1'b1;
            ptr_q   <= ptr_d;
            state_q <= S_GAP;
          end else if (count_q == '0) begin
            gnt_q   <= '0;
            done_q  <= gnt_q;
            ptr_q   <= ptr_d;
            state_q <= S_GAP;
          end else if (!HOLD) begin
            count_q <= count_q - WIDTH'(1);
          end
        end
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign GNT         = gnt_q;
  assign GNT_ID      = gnt_id_q;
  assign DONE        = done_q;
  assign ABORT       = abort_q;
  assign BUSY        = (state_q == S_COUNT);
  assign COUNT       = count_q;
  assign EXPIRE      = BUSY && (count_q == '0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gp_timer_scheduler.sv
// Bench for gp_timer_scheduler: directed scenarios followed by random traffic, checked
// every cycle against a transaction-level model of owner / remaining-count / pointer.
module tb_gp_timer_scheduler;

  localparam int N = 4;
  localparam int W = 14;

  // ---------------- clock / reset ----------------
  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic           HOLD;
  logic [N*W-1:0] TIMEOUT;
  logic [N-1:0]   GNT;
  logic [1:0]     GNT_ID;
  logic [N-1:0]   DONE;
  logic           ABORT;
  logic           BUSY;
  logic [W-1:0]   COUNT;
  logic           EXPIRE;
  logic [1:0]     dbg_state;

  always #5 CLK = ~CLK;

  gp_timer_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .HOLD(HOLD), .TIMEOUT(TIMEOUT),
    .GNT(GNT), .GNT_ID(GNT_ID), .DONE(DONE), .ABORT(ABORT), .BUSY(BUSY),
    .COUNT(COUNT), .EXPIRE(EXPIRE), .dbg_state_o(dbg_state)
  );

  // ---------------- reference model ----------------
  int  n_cmp = 0;
  int  n_err = 0;
  int  m_owner;      // requester holding the counter, -1 when none
  int  m_rem;        // value the shared counter shows
  int  m_ptr;        // requester searched first at next arbitration
  int  m_last;       // most recent grant
  int  m_done;       // requester finishing this cycle, -1 when none
  bit  m_abort;
  bit  m_gap;        // dead cycle after a grant ends
  logic [2:0] exp_q[$];
  int  gorder[$];
  logic [N-1:0] prev_gnt;

  function automatic int pick();
`ifdef GP_TIMER_SCHED_PRIO_EN
    if (REQ[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (REQ[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rem = 0; m_ptr = 0; m_last = 0;
    m_done = -1; m_abort = 0; m_gap = 0;
    exp_q.delete();
    prev_gnt = '0;
  endtask

  task automatic model_step();
    int j;
    m_done  = -1;
    m_abort = 0;
    if (m_owner >= 0) begin
      if (!REQ[m_owner]) begin
        m_abort = 1; m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = 1;
      end else if (m_rem == 0) begin
        m_done = m_owner; m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = 1;
      end else if (!HOLD) begin
        m_rem = m_rem - 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      j = pick();
      if (j >= 0) begin
        m_owner = j; m_last = j;
        m_rem = int'(TIMEOUT[j*W +: W]);
        exp_q.push_back(3'(j));
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_gnt, e_done;
    logic [2:0]   e_id;
    e_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_done = (m_done >= 0) ? (N'(1) << m_done) : '0;
    chk("gnt",    32'(GNT),    32'(e_gnt));
    chk("gnt_id", 32'(GNT_ID), 32'(m_last));
    chk("done",   32'(DONE),   32'(e_done));
    chk("abort",  32'(ABORT),  32'(m_abort));
    chk("busy",   32'(BUSY),   32'(m_owner >= 0));
    chk("count",  32'(COUNT),  32'(m_rem));
    chk("expire", 32'(EXPIRE), 32'((m_owner >= 0) && (m_rem == 0)));
    if (GNT !== '0 && prev_gnt === '0) begin
      e_id = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd7;
      chk("sb_order", 32'(GNT_ID), 32'(e_id));
      gorder.push_back(int'(GNT_ID));
    end
    prev_gnt = GNT;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  // Called just after an edge: reset is asserted and released between edges.
  task automatic do_reset();
    RST = 1'b1;
    #1;
    model_reset();
    check_all();
    #2;
    RST = 1'b0;
  endtask

  task automatic set_tmo(input int i, input int v);
    TIMEOUT[i*W +: W] = W'(v);
  endtask

  task automatic idle_out();
    REQ = '0; HOLD = 1'b0;
    repeat (3) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bit seen;
    RST = 1'b1; REQ = '0; HOLD = 1'b0; TIMEOUT = '0;
    #2;
    model_reset();
    check_all();
    @(posedge CLK); #1;
    RST = 1'b0;

    // single request, T=3
    do_reset();
    set_tmo(1, 3); REQ = 4'b0010;
    step(); chk("t1_first_cnt", 32'(COUNT), 32'd3); chk("t1_gnt", 32'(GNT), 32'b0010);
    repeat (3) step();
    chk("t1_cnt_zero", 32'(COUNT), 32'd0); chk("t1_expire", 32'(EXPIRE), 32'd1);
    step(); chk("t1_done", 32'(DONE), 32'b0010); chk("t1_gnt_off", 32'(GNT), 32'd0);
    step(); chk("t1_gap_done", 32'(DONE), 32'd0);
    step(); chk("t1_regrant", 32'(GNT), 32'b0010);
    idle_out();

    // round-robin over all four, T=1
    do_reset();
    for (int i = 0; i < N; i++) set_tmo(i, 1);
    REQ = 4'b1111;
    gorder.delete();
    repeat (18) step();
    for (int k = 0; k < 5; k++) begin
`ifdef GP_TIMER_SCHED_PRIO_EN
      chk("t2_order", 32'(gorder[k]), 32'd0);
`else
      chk("t2_order", 32'(gorder[k]), 32'(k % N));
`endif
    end
    idle_out();

    // abort of requester 2 at COUNT=6, requester 3 pending
    do_reset();
    set_tmo(2, 10); set_tmo(3, 2); REQ = 4'b1100;
    step(); chk("t3_gnt_id", 32'(GNT_ID), 32'd2);
    repeat (4) step();
    chk("t3_cnt6", 32'(COUNT), 32'd6);
    REQ = 4'b1000;
    step();
    chk("t3_abort", 32'(ABORT), 32'd1); chk("t3_no_done", 32'(DONE), 32'd0);
    chk("t3_cnt_held", 32'(COUNT), 32'd6); chk("t3_gnt_off", 32'(GNT), 32'd0);
    step(); chk("t3_abort_clr", 32'(ABORT), 32'd0);
    step(); chk("t3_next", 32'(GNT_ID), 32'd3);
    idle_out();

    // HOLD for three edges at COUNT=4, T=5
    do_reset();
    set_tmo(0, 5); REQ = 4'b0001; cyc = 0;
    step(); if (GNT !== '0) cyc++;
    step(); if (GNT !== '0) cyc++;
    HOLD = 1'b1;
    repeat (3) begin
      step(); if (GNT !== '0) cyc++;
      chk("t4_hold_cnt", 32'(COUNT), 32'd4);
    end
    HOLD = 1'b0; seen = 0;
    for (int s = 0; s < 20 && !seen; s++) begin
      step();
      if (GNT !== '0) cyc++;
      if (m_done >= 0) seen = 1;
    end
    chk("t4_done_seen", 32'(seen), 32'd1);
    chk("t4_done", 32'(DONE), 32'b0001);
    chk("t4_gnt_len", 32'(cyc), 32'd9);
    REQ = '0;
    repeat (2) step();

    // asynchronous reset at COUNT=7
    do_reset();
    set_tmo(0, 9); REQ = 4'b0001;
    repeat (3) step();
    chk("t5_cnt7", 32'(COUNT), 32'd7);
    do_reset();
    chk("t5_gnt", 32'(GNT), 32'd0); chk("t5_busy", 32'(BUSY), 32'd0);
    chk("t5_cnt", 32'(COUNT), 32'd0);
    REQ = 4'b1000; set_tmo(3, 1);
    step(); chk("t5_gnt3", 32'(GNT_ID), 32'd3); chk("t5_gnt3_hot", 32'(GNT), 32'b1000);
    idle_out();

    // requester 0 versus round-robin pointer at 2
    do_reset();
    set_tmo(0, 1); set_tmo(1, 2); set_tmo(2, 1); REQ = 4'b0010;
    repeat (4) step();
    chk("t6_done1", 32'(DONE), 32'b0010);
    REQ = 4'b0101;
    step();
    step();
`ifdef GP_TIMER_SCHED_PRIO_EN
    chk("t6_winner", 32'(GNT_ID), 32'd0);
`else
    chk("t6_winner", 32'(GNT_ID), 32'd2);
`endif
    idle_out();

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (REQ[i]) begin
          if (m_owner == i && $urandom_range(0, 15) == 0) REQ[i] = 1'b0;
          else if (m_done == i && $urandom_range(0, 1) == 0) REQ[i] = 1'b0;
          else if (m_owner != i && $urandom_range(0, 31) == 0) REQ[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          REQ[i] = 1'b1;
        end
        set_tmo(i, $urandom_range(0, 5));
      end
      HOLD = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end
    idle_out();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
